// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// the grant-index width helper.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE picks a winner, BURST streams that winner's beats.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Width of a producer index (GRANT_W); never narrower than one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: finds the first asserted request
// starting just after last_grant, wrapping modulo NUM_REQ.
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    // src[k] is the producer index sitting at rotated position k, so the
    // same table rotates the request vector and un-rotates the winner.
    logic [NUM_REQ-1:0] rot;
    logic [GRANT_W-1:0] src [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign src[gi] = GRANT_W'((int'(last_grant) + 1 + gi) % NUM_REQ);
        assign rot[gi] = req[src[gi]];
    end

    // Priority-encode the rotated vector (lowest offset wins) and map back.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = src[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a synchronous FIFO. One producer
// holds the grant for up to MAX_BURST beats; writes are gated by fifo_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic                            grant_valid,
    output logic [grant_width(NUM_REQ)-1:0] grant_id
);

    localparam int GRANT_W = grant_width(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(MAX_BURST - 1);
    localparam logic [GRANT_W-1:0] RESET_LAST = GRANT_W'(NUM_REQ - 1);

    state_t             state_reg, state_next;
    logic [GRANT_W-1:0] grant_id_reg, grant_id_next;
    logic               grant_valid_reg, grant_valid_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [GRANT_W-1:0] last_grant_reg, last_grant_next;

    logic                  pick_found;
    logic [GRANT_W-1:0]    pick_idx;
    logic                  sel_valid;
    logic                  accept;
    logic                  release_grant;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // Handshake is combinational from the registered grant: only the
    // granted producer can see ready, and never while the FIFO is full.
    assign sel_valid = req_valid[grant_id_reg];
    assign accept    = (state_reg == ST_BURST) && sel_valid && !fifo_full;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = accept && (grant_id_reg == GRANT_W'(gi));
    end

    assign fifo_wr_en   = accept;
    assign fifo_data_in = (state_reg == ST_BURST) ? data_arr[grant_id_reg] : '0;
    assign grant_valid  = grant_valid_reg;
    assign grant_id     = grant_id_reg;

    // Next-state logic: arbitrate in IDLE, count beats and decide release in BURST.
    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        beat_cnt_next    = beat_cnt_reg;
        last_grant_next  = last_grant_reg;
        release_grant    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_next    = pick_idx;
                    grant_valid_next = 1'b1;
                    beat_cnt_next    = '0;
                    state_next       = ST_BURST;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        release_grant = 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end else if (!sel_valid) begin
                    release_grant = 1'b1;
                end
                // Full with valid held: stall with grant and count frozen.
            end
            default: state_next = ST_IDLE;
        endcase

        // Releasing remembers the owner so the next scan starts after it.
        if (release_grant) begin
            last_grant_next  = grant_id_reg;
            grant_valid_next = 1'b0;
            grant_id_next    = '0;
            beat_cnt_next    = '0;
            state_next       = ST_IDLE;
        end
    end

    // Grant state register; reset aborts any burst and favours producer 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
            beat_cnt_reg    <= '0;
            last_grant_reg  <= RESET_LAST;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            beat_cnt_reg    <= beat_cnt_next;
            last_grant_reg  <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level arbitration model and
// a FIFO scoreboard.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 8;
    localparam int GW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data_in;
    logic             grant_valid;
    logic [GW-1:0]    grant_id;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]    pq [NR][$];   // per-producer pending words
    logic [NR-1:0] en;           // producer willing to present its head word
    logic          rd;           // consumer pops the FIFO this cycle
    logic [7:0]    fifo_q [$];   // behavioural FIFO contents
    logic [7:0]    exp_q [$];    // expected FIFO output order
    logic [7:0]    rdlog [$];
    int            glog [$];     // producers in the order they were granted
    logic          prev_gv;
    logic [NR-1:0] hold;
    logic [7:0]    hold_data [NR];

    // Reference model: current owner (-1 none), beats taken, last owner.
    int m_owner;
    int m_cnt;
    int m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = en[i] && (pq[i].size() > 0);
            req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    function automatic logic busy();
        logic b;
        b = (fifo_q.size() > 0) || (m_owner >= 0);
        for (int i = 0; i < NR; i++) if (pq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NR; i++) pq[i].delete();
        en = '0;
        hold = '0;
        glog.delete();
        rdlog.delete();
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        logic          exp_acc;
        logic [NR-1:0] exp_ready;
        logic [7:0]    exp_data;
        logic          wr;
        logic          full_before;
        logic [7:0]    wdata;
        logic [7:0]    v;
        logic [31:0]   ev;
        logic          found;
        int            k;

        drive();
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hold[i]) begin
                chk("stable_valid", 32'(req_valid[i]), 32'd1);
                chk("stable_data", 32'(req_data[i*DW +: DW]), 32'(hold_data[i]));
            end
        end

        exp_acc   = 1'b0;
        exp_ready = '0;
        exp_data  = 8'h00;
        if (m_owner >= 0) begin
            exp_data = req_data[m_owner*DW +: DW];
            if (req_valid[m_owner] && !fifo_full) begin
                exp_acc = 1'b1;
                exp_ready[m_owner] = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_acc));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(exp_data));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("grant_id", 32'(grant_id), (m_owner >= 0) ? m_owner : 0);

        if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
        prev_gv     = grant_valid;
        wr          = fifo_wr_en;
        wdata       = fifo_data_in;
        full_before = fifo_full;
        for (int i = 0; i < NR; i++) begin
            hold[i]      = req_valid[i] && !req_ready[i];
            hold_data[i] = req_data[i*DW +: DW];
            if (req_valid[i] && req_ready[i]) void'(pq[i].pop_front());
        end

        if (exp_acc) exp_q.push_back(exp_data);
        if (m_owner < 0) begin
            found = 1'b0;
            for (int s = 1; s <= NR; s++) begin
                k = (m_last + s) % NR;
                if (!found && req_valid[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_cnt   = 0;
                end
            end
        end else if (exp_acc) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end

        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            v = fifo_q.pop_front();
            rdlog.push_back(v);
            ev = 32'hFFFF_FFFF;
            if (exp_q.size() > 0) ev = 32'(exp_q.pop_front());
            chk("fifo_order", 32'(v), ev);
        end
        if (wr && !full_before) fifo_q.push_back(wdata);
        @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        drive();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_fifo_data_in", 32'(fifo_data_in), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_owner = -1;
        m_cnt   = 0;
        m_last  = NR - 1;
        prev_gv = 1'b0;
        fifo_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        en = '1;
        rd = 1'b1;
        for (int c = 0; c < 300 && busy(); c++) tick();
        chk("drain_done", 32'(busy()), 32'd0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; en = '0; rd = 1'b0; hold = '0; prev_gv = 1'b0;
        req_valid = '0; req_data = '0; fifo_full = 1'b0;
        m_owner = -1; m_cnt = 0; m_last = NR - 1;
        @(negedge clk);
        do_reset();

        // Producer 0 alone: 4-beat burst, bubble, re-grant, release on valid drop.
        for (int b = 0; b < 6; b++) pq[0].push_back(8'(8'h10 + b));
        en[0] = 1'b1;
        repeat (10) tick();
        chk("t2_grant_count", glog.size(), 2);
        for (int g = 0; g < 2 && g < glog.size(); g++) chk("t2_grant_id", glog[g], 0);
        rd = 1'b1;
        repeat (8) tick();
        rd = 1'b0;
        chk("t2_readback_n", rdlog.size(), 6);
        for (int b = 0; b < 6 && b < rdlog.size(); b++)
            chk("t2_readback", 32'(rdlog[b]), 32'(8'h10 + b));
        clear_all();

        // Reset in the middle of producer 1's burst.
        for (int b = 0; b < 3; b++) pq[1].push_back(8'(8'hC1 + b));
        en[1] = 1'b1;
        repeat (2) tick();
        chk("t1_ready_before_rst", 32'(req_ready), 32'd2);
        do_reset();
        clear_all();

        // All producers busy, consumer draining: fair rotation 0,1,2,3,0.
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 8; b++) pq[i].push_back(8'(8'hA0 + i*16 + b));
        en = '1;
        rd = 1'b1;
        repeat (26) tick();
        chk("t3_grant_count", 32'(glog.size() >= 5), 32'd1);
        for (int g = 0; g < 5 && g < glog.size(); g++) chk("t3_grant_order", glog[g], g % NR);
        drain();
        clear_all();

        // FIFO at 7 entries: one write fills it, then stall until a read.
        rd = 1'b0;
        for (int k = 0; k < 7; k++) begin
            fifo_q.push_back(8'(8'hE0 + k));
            exp_q.push_back(8'(8'hE0 + k));
        end
        pq[2].push_back(8'h31); pq[2].push_back(8'h32); pq[2].push_back(8'h33);
        en[2] = 1'b1;
        repeat (5) tick();
        chk("t4_fifo_count", fifo_q.size(), DEPTH);
        chk("t4_pending", pq[2].size(), 2);
        chk("t4_grant_held", 32'(grant_valid), 32'd1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        chk("t4_after_read_pending", pq[2].size(), 1);
        chk("t4_after_read_tail", 32'(fifo_q[fifo_q.size()-1]), 32'h32);
        drain();
        clear_all();

        // Producer 1 drops valid after two beats; rotation continues 2,3,0.
        rd = 1'b1;
        pq[1].push_back(8'h51); pq[1].push_back(8'h52);
        en[1] = 1'b1;
        tick();
        pq[0].push_back(8'h61); pq[0].push_back(8'h62);
        pq[2].push_back(8'h71); pq[2].push_back(8'h72);
        pq[3].push_back(8'h81); pq[3].push_back(8'h82);
        en = '1;
        repeat (20) tick();
        chk("t5_grant_count", glog.size(), 4);
        for (int g = 0; g < 4 && g < glog.size(); g++) chk("t5_grant_order", glog[g], (g + 1) % NR);
        drain();
        clear_all();

        // Reset mid-burst of producer 3; producer 0 then wins first.
        rd = 1'b1;
        for (int b = 0; b < 6; b++) pq[3].push_back(8'(8'h91 + b));
        en[3] = 1'b1;
        repeat (3) tick();
        chk("t6_owner", 32'(grant_id), 32'd3);
        pq[0].push_back(8'hB1); pq[0].push_back(8'hB2);
        en[0] = 1'b1;
        do_reset();
        glog.delete();
        repeat (4) tick();
        chk("t6_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("t6_p3_head", 32'(pq[3][0]), 32'h93);
        drain();
        clear_all();

        // Random traffic with a slow consumer so the FIFO fills regularly.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (pq[i].size() < 3 && $urandom_range(0, 3) == 0) pq[i].push_back(8'($urandom));
                if (!hold[i]) en[i] = ($urandom_range(0, 3) != 0);
            end
            rd = ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
